// File: rtl/mo_lightpen_mouse.sv
// Purpose : MO5/MO6 light pen emulated from the host PS/2 mouse. Relative motion
//           from toggle-framed packets is accumulated into an absolute pen position
//           clamped to the 320x200 active area; o_pen_hit pulses when the beam
//           passes under the pen.
// Latency : toggle change sampled at edge 0 -> pen outputs and o_pen_moved at edge 4.
//           o_pen_hit is registered, one cycle after the matching pixel.
// Flow    : no backpressure. A packet that arrives while one is still pending
//           replaces it, and the older deltas are dropped.
//
// Ports
//   i_clk_sys     system clock
//   i_reset       asynchronous active-high reset
//   i_ps2_mouse   [2:0] L/R/M buttons, [4] X sign, [5] Y sign, [15:8] X delta,
//                 [23:16] Y delta, [24] toggle that flips once per packet
//   i_pix_ce      pixel clock enable
//   i_hpos        beam pixel index, valid while i_vid_active is high
//   i_vpos        beam line index, valid while i_vid_active is high
//   i_vid_active  beam is inside the active area
//   o_pen_x       committed pen X, 0..H_ACTIVE-1
//   o_pen_y       committed pen Y, 0..V_ACTIVE-1
//   o_pen_button  left button of the last committed packet
//   o_pen_hit     one-cycle pulse: beam under the pen
//   o_pen_moved   one-cycle pulse at each commit
module mo_lightpen_mouse #(
   parameter int H_ACTIVE    = 320,
   parameter int V_ACTIVE    = 200,
   parameter int INIT_X      = 160,
   parameter int INIT_Y      = 100,
   parameter int SPEED_SHIFT = 0,
   parameter int HIT_WIDTH   = 2
) (
   input  logic        i_clk_sys,
   input  logic        i_reset,
   input  logic [24:0] i_ps2_mouse,
   input  logic        i_pix_ce,
   input  logic [8:0]  i_hpos,
   input  logic [7:0]  i_vpos,
   input  logic        i_vid_active,
   output logic [8:0]  o_pen_x,
   output logic [7:0]  o_pen_y,
   output logic        o_pen_button,
   output logic        o_pen_hit,
   output logic        o_pen_moved
);

   typedef enum logic [2:0] {
      ST_ARM,
      ST_IDLE,
      ST_SUM,
      ST_CLAMP,
      ST_COMMIT
   } state_t;

   localparam logic signed [10:0] L_XMAX = 11'(H_ACTIVE - 1);
   localparam logic signed [10:0] L_YMAX = 11'(V_ACTIVE - 1);

   state_t             r_state;
   logic               r_tog_q;
   logic               r_pend;
   logic [23:0]        r_pkt;
   logic signed [10:0] r_sx;
   logic signed [10:0] r_sy;
   logic [8:0]         r_cx;
   logic [7:0]         r_cy;
   logic               r_btn;
   logic [8:0]         r_pen_x;
   logic [7:0]         r_pen_y;
   logic               r_pen_button;
   logic               r_pen_hit;
   logic               r_pen_moved;

   logic               w_new_pkt;
   logic signed [8:0]  w_dx9;
   logic signed [8:0]  w_dy9;
   logic signed [10:0] w_sx;
   logic signed [10:0] w_sy;
   logic [8:0]         w_cx;
   logic [7:0]         w_cy;
   logic               w_hit;

   // ARM swallows whatever toggle level is present at reset release.
   assign w_new_pkt = (r_state != ST_ARM) && (i_ps2_mouse[24] != r_tog_q);

   assign w_dx9 = $signed({r_pkt[4], r_pkt[15:8]}) >>> SPEED_SHIFT;
   assign w_dy9 = $signed({r_pkt[5], r_pkt[23:16]}) >>> SPEED_SHIFT;

   // PS/2 +Y points up while screen lines count downwards.
   assign w_sx = $signed({2'b00, r_pen_x}) + $signed({{2{w_dx9[8]}}, w_dx9});
   assign w_sy = $signed({3'b000, r_pen_y}) - $signed({{2{w_dy9[8]}}, w_dy9});

   assign w_cx = r_sx[10] ? 9'd0 : ((r_sx > L_XMAX) ? L_XMAX[8:0] : r_sx[8:0]);
   assign w_cy = r_sy[10] ? 8'd0 : ((r_sy > L_YMAX) ? L_YMAX[7:0] : r_sy[7:0]);

   // Compare one bit wider so pen_x+HIT_WIDTH-1 cannot wrap.
   assign w_hit = i_pix_ce && i_vid_active && (i_vpos == r_pen_y) &&
                  ({1'b0, i_hpos} >= {1'b0, r_pen_x}) &&
                  ({1'b0, i_hpos} <= ({1'b0, r_pen_x} + 10'(HIT_WIDTH - 1)));

   always_ff @(posedge i_clk_sys or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= ST_ARM;
         r_tog_q      <= 1'b0;
         r_pend       <= 1'b0;
         r_pkt        <= '0;
         r_sx         <= '0;
         r_sy         <= '0;
         r_cx         <= '0;
         r_cy         <= '0;
         r_btn        <= 1'b0;
         r_pen_x      <= 9'(INIT_X);
         r_pen_y      <= 8'(INIT_Y);
         r_pen_button <= 1'b0;
         r_pen_hit    <= 1'b0;
         r_pen_moved  <= 1'b0;
      end else begin
         r_pen_hit   <= w_hit;
         r_pen_moved <= 1'b0;

         if (w_new_pkt) begin
            r_tog_q <= i_ps2_mouse[24];
            r_pkt   <= i_ps2_mouse[23:0];
            r_pend  <= 1'b1;
         end

         case (r_state)
            ST_ARM: begin
               r_tog_q <= i_ps2_mouse[24];
               r_state <= ST_IDLE;
            end
            ST_IDLE: begin
               // Clearing pend wins over a packet landing on this edge: that
               // packet is already in r_pkt when SUM reads it, so it is used
               // once and never committed a second time.
               if (r_pend) begin
                  r_pend  <= 1'b0;
                  r_state <= ST_SUM;
               end
            end
            ST_SUM: begin
               r_sx    <= w_sx;
               r_sy    <= w_sy;
               r_btn   <= r_pkt[0];
               r_state <= ST_CLAMP;
            end
            ST_CLAMP: begin
               r_cx    <= w_cx;
               r_cy    <= w_cy;
               r_state <= ST_COMMIT;
            end
            ST_COMMIT: begin
               r_pen_x      <= r_cx;
               r_pen_y      <= r_cy;
               r_pen_button <= r_btn;
               r_pen_moved  <= 1'b1;
               r_state      <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_pen_x      = r_pen_x;
   assign o_pen_y      = r_pen_y;
   assign o_pen_button = r_pen_button;
   assign o_pen_hit    = r_pen_hit;
   assign o_pen_moved  = r_pen_moved;

endmodule

// File: tb/tb_mo_lightpen_mouse.sv
// Bench for mo_lightpen_mouse: two instances (SPEED_SHIFT 0 and 2) share all
// inputs; an abstract pen model predicts position, button, commits and hits.
module tb_mo_lightpen_mouse;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [24:0] ps2 = '0;
   logic        pix_ce = 1'b0;
   logic [8:0]  hpos = '0;
   logic [7:0]  vpos = '0;
   logic        vid_active = 1'b0;

   logic [1:0][8:0] px;
   logic [1:0][7:0] py;
   logic [1:0]      pb;
   logic [1:0]      hit;
   logic [1:0]      mv;

   int n_cmp = 0;
   int n_bad = 0;
   int mv_cnt [2];
   int mx [2];
   int my [2];
   int mb [2];
   logic tog = 1'b0;

   always #5 clk = ~clk;

   mo_lightpen_mouse #(.SPEED_SHIFT(0)) dut0 (
      .i_clk_sys(clk), .i_reset(rst), .i_ps2_mouse(ps2), .i_pix_ce(pix_ce),
      .i_hpos(hpos), .i_vpos(vpos), .i_vid_active(vid_active),
      .o_pen_x(px[0]), .o_pen_y(py[0]), .o_pen_button(pb[0]),
      .o_pen_hit(hit[0]), .o_pen_moved(mv[0]));

   mo_lightpen_mouse #(.SPEED_SHIFT(2)) dut1 (
      .i_clk_sys(clk), .i_reset(rst), .i_ps2_mouse(ps2), .i_pix_ce(pix_ce),
      .i_hpos(hpos), .i_vpos(vpos), .i_vid_active(vid_active),
      .o_pen_x(px[1]), .o_pen_y(py[1]), .o_pen_button(pb[1]),
      .o_pen_hit(hit[1]), .o_pen_moved(mv[1]));

   initial begin
      mv_cnt[0] = 0;
      mv_cnt[1] = 0;
   end

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++)
         if (mv[k] === 1'b1) mv_cnt[k] = mv_cnt[k] + 1;
   end

   // ---------------- reference model ----------------
   function automatic int shift_of(input int k);
      return (k == 0) ? 0 : 2;
   endfunction

   // Floor division by 2^s, i.e. what an arithmetic right shift means.
   function automatic int scale(input int d, input int s);
      int q;
      q = d / (1 << s);
      if (d < 0 && (q * (1 << s)) != d) q = q - 1;
      return q;
   endfunction

   function automatic int clampi(input int v, input int hi);
      if (v < 0) return 0;
      if (v > hi) return hi;
      return v;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mx[k] = 160; my[k] = 100; mb[k] = 0;
      end
   endtask

   task automatic model_move(input int dx, input int dy, input int btn);
      for (int k = 0; k < 2; k++) begin
         mx[k] = clampi(mx[k] + scale(dx, shift_of(k)), 319);
         my[k] = clampi(my[k] - scale(dy, shift_of(k)), 199);
         mb[k] = btn & 1;
      end
   endtask

   function automatic logic model_hit(input int k, input logic ce, input logic va,
                                      input int h, input int v);
      return ce && va && (v == my[k]) && (h >= mx[k]) && (h <= mx[k] + 1);
   endfunction

   // ---------------- stimulus primitives ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [24:0] pack(input logic t, input int dx, input int dy,
                                        input int btn);
      logic [8:0] x9;
      logic [8:0] y9;
      logic [2:0] b3;
      x9 = 9'(dx);
      y9 = 9'(dy);
      b3 = 3'(btn);
      return {t, y9[7:0], x9[7:0], 2'b00, y9[8], x9[8], 1'b0, b3};
   endfunction

   task automatic send(input int dx, input int dy, input int btn);
      tog = ~tog;
      ps2 = pack(tog, dx, dy, btn);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
      tog = ps2[24];
      model_reset();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      int m0 [2];
      ps2 = '0;
      tog = 1'b0;
      rst = 1'b1;
      tick(1);
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (px[k] !== 9'd160 || py[k] !== 8'd100 || pb[k] !== 1'b0 ||
             hit[k] !== 1'b0 || mv[k] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state dut%0d: got x=%0d y=%0d b=%b hit=%b mv=%b, need 160 100 0 0 0",
                     k, px[k], py[k], pb[k], hit[k], mv[k]);
         end
      end
      rst = 1'b0;
      tick(1);
      model_reset();
      m0[0] = mv_cnt[0]; m0[1] = mv_cnt[1];
      tick(20);
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (mv_cnt[k] - m0[k] !== 0 || px[k] !== 9'd160 || py[k] !== 8'd100) begin
            n_bad++;
            $display("FAIL reset_idle dut%0d: got x=%0d y=%0d commits=%0d, need 160 100 0",
                     k, px[k], py[k], mv_cnt[k] - m0[k]);
         end
      end
   endtask

   task automatic test_move_latency();
      send(10, 5, 1);
      tick(4);   // edges 0..3
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (px[k] !== 9'(mx[k]) || py[k] !== 8'(my[k]) || mv[k] !== 1'b0) begin
            n_bad++;
            $display("FAIL latency_early dut%0d: got x=%0d y=%0d mv=%b, need %0d %0d 0",
                     k, px[k], py[k], mv[k], mx[k], my[k]);
         end
      end
      model_move(10, 5, 1);
      tick(1);   // edge 4
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (px[k] !== 9'(mx[k]) || py[k] !== 8'(my[k]) || pb[k] !== 1'(mb[k]) ||
             mv[k] !== 1'b1) begin
            n_bad++;
            $display("FAIL latency_commit dut%0d: got x=%0d y=%0d b=%b mv=%b, need %0d %0d %0d 1",
                     k, px[k], py[k], pb[k], mv[k], mx[k], my[k], mb[k]);
         end
      end
      n_cmp++;
      if (px[0] !== 9'd170 || py[0] !== 8'd95) begin
         n_bad++;
         $display("FAIL move_abs: got x=%0d y=%0d, need 170 95", px[0], py[0]);
      end
      tick(1);
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (mv[k] !== 1'b0) begin
            n_bad++;
            $display("FAIL moved_pulse_width dut%0d: got mv=%b, need 0", k, mv[k]);
         end
      end
   endtask

   task automatic test_hit();
      logic ce, va, e;
      int v;
      for (int pass = 0; pass < 4; pass++) begin
         for (int h = 0; h < 320; h++) begin
            v  = (pass == 1) ? my[0] - 1 : my[0];
            ce = (pass == 3) ? 1'b0 : 1'b1;
            va = (pass == 2) ? 1'b0 : 1'b1;
            hpos = 9'(h); vpos = 8'(v); pix_ce = ce; vid_active = va;
            tick(1);
            for (int k = 0; k < 2; k++) begin
               e = model_hit(k, ce, va, h, v);
               n_cmp++;
               if (hit[k] !== e) begin
                  n_bad++;
                  $display("FAIL hit_sweep dut%0d pass%0d h=%0d v=%0d: got %b, need %b",
                           k, pass, h, v, hit[k], e);
               end
            end
         end
      end
      pix_ce = 1'b0; vid_active = 1'b0;
      tick(1);
   endtask

   task automatic test_clamp();
      int dx [5] = '{-155, -256, 255, 255, 255};
      int dy [5] = '{-99, -100, 0, 0, 0};
      for (int i = 0; i < 5; i++) begin
         send(dx[i], dy[i], i & 1);
         tick(6);
         model_move(dx[i], dy[i], i & 1);
         for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (px[k] !== 9'(mx[k]) || py[k] !== 8'(my[k]) || pb[k] !== 1'(mb[k])) begin
               n_bad++;
               $display("FAIL clamp step%0d dut%0d: got x=%0d y=%0d b=%b, need %0d %0d %0d",
                        i, k, px[k], py[k], pb[k], mx[k], my[k], mb[k]);
            end
         end
         if (i == 1) begin
            n_cmp++;
            if (px[0] !== 9'd0 || py[0] !== 8'd199) begin
               n_bad++;
               $display("FAIL clamp_low: got x=%0d y=%0d, need 0 199", px[0], py[0]);
            end
         end
      end
      n_cmp++;
      if (px[0] !== 9'd319) begin
         n_bad++;
         $display("FAIL clamp_high: got x=%0d, need 319", px[0]);
      end
   endtask

   task automatic test_arm_and_overwrite();
      int m0 [2];
      ps2 = pack(1'b1, 40, -30, 1);
      do_reset();
      m0[0] = mv_cnt[0]; m0[1] = mv_cnt[1];
      tick(10);
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (px[k] !== 9'd160 || py[k] !== 8'd100 || mv_cnt[k] - m0[k] !== 0) begin
            n_bad++;
            $display("FAIL arm_no_move dut%0d: got x=%0d y=%0d commits=%0d, need 160 100 0",
                     k, px[k], py[k], mv_cnt[k] - m0[k]);
         end
      end
      m0[0] = mv_cnt[0]; m0[1] = mv_cnt[1];
      send(100, 50, 0);
      tick(1);
      send(-20, 12, 1);
      tick(12);
      model_move(-20, 12, 1);
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (px[k] !== 9'(mx[k]) || py[k] !== 8'(my[k]) || pb[k] !== 1'(mb[k]) ||
             mv_cnt[k] - m0[k] !== 1) begin
            n_bad++;
            $display("FAIL overwrite dut%0d: got x=%0d y=%0d b=%b commits=%0d, need %0d %0d %0d 1",
                     k, px[k], py[k], pb[k], mv_cnt[k] - m0[k], mx[k], my[k], mb[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int m0 [2];
      m0[0] = mv_cnt[0]; m0[1] = mv_cnt[1];
      send(33, -17, 1);
      tick(3);
      send(-50, 21, 0);
      tick(14);
      model_move(33, -17, 1);
      model_move(-50, 21, 0);
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (px[k] !== 9'(mx[k]) || py[k] !== 8'(my[k]) || pb[k] !== 1'(mb[k]) ||
             mv_cnt[k] - m0[k] !== 2) begin
            n_bad++;
            $display("FAIL back_to_back dut%0d: got x=%0d y=%0d b=%b commits=%0d, need %0d %0d %0d 2",
                     k, px[k], py[k], pb[k], mv_cnt[k] - m0[k], mx[k], my[k], mb[k]);
         end
      end
   endtask

   task automatic test_reset_midflight();
      int m0 [2];
      m0[0] = mv_cnt[0]; m0[1] = mv_cnt[1];
      send(60, 60, 1);
      tick(3);   // edges 0..2: pipeline sits between SUM and COMMIT
      do_reset();
      tick(8);
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (px[k] !== 9'd160 || py[k] !== 8'd100 || pb[k] !== 1'b0 ||
             mv_cnt[k] - m0[k] !== 0) begin
            n_bad++;
            $display("FAIL reset_midflight dut%0d: got x=%0d y=%0d b=%b commits=%0d, need 160 100 0 0",
                     k, px[k], py[k], pb[k], mv_cnt[k] - m0[k]);
         end
      end
   endtask

   task automatic test_speed_shift();
      send(-7, 0, 0);
      tick(6);
      model_move(-7, 0, 0);
      n_cmp++;
      if (px[1] !== 9'd158 || px[0] !== 9'd153) begin
         n_bad++;
         $display("FAIL speed_shift: got x1=%0d x0=%0d, need 158 153", px[1], px[0]);
      end
   endtask

   task automatic test_random();
      int dx, dy, b, v, h;
      logic ce, va, e;
      for (int i = 0; i < 40; i++) begin
         dx = int'($urandom_range(0, 511)) - 256;
         dy = int'($urandom_range(0, 511)) - 256;
         b  = int'($urandom_range(0, 7));
         send(dx, dy, b);
         tick(5 + int'($urandom_range(0, 3)));
         model_move(dx, dy, b);
         for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (px[k] !== 9'(mx[k]) || py[k] !== 8'(my[k]) || pb[k] !== 1'(mb[k])) begin
               n_bad++;
               $display("FAIL random_move%0d dut%0d: got x=%0d y=%0d b=%b, need %0d %0d %0d",
                        i, k, px[k], py[k], pb[k], mx[k], my[k], mb[k]);
            end
         end
         for (int c = 0; c < 40; c++) begin
            v  = clampi(my[c & 1] + int'($urandom_range(0, 2)) - 1, 199);
            h  = clampi(mx[c & 1] + int'($urandom_range(0, 6)) - 3, 319);
            ce = 1'($urandom_range(0, 3) != 0);
            va = 1'($urandom_range(0, 3) != 0);
            hpos = 9'(h); vpos = 8'(v); pix_ce = ce; vid_active = va;
            tick(1);
            for (int k = 0; k < 2; k++) begin
               e = model_hit(k, ce, va, h, v);
               n_cmp++;
               if (hit[k] !== e) begin
                  n_bad++;
                  $display("FAIL random_hit dut%0d h=%0d v=%0d: got %b, need %b",
                           k, h, v, hit[k], e);
               end
            end
         end
         pix_ce = 1'b0; vid_active = 1'b0;
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_move_latency();
      test_hit();
      test_clamp();
      test_arm_and_overwrite();
      test_back_to_back();
      test_reset_midflight();
      test_speed_shift();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
